// File: rtl/mvb_pkg.sv
// Shared MVB receive definitions: FSM states, CRC7 constants and frame-size helpers.
// Used by the frame receiver and by the future transmit loopback checker.
package mvb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_CHECK,
        ST_END,
        ST_DONE
    } mvb_state_t;

    localparam logic [6:0] MVB_CRC_POLY    = 7'h65;
    localparam int         MVB_GROUP_BITS  = 64;
    localparam int         MVB_MASTER_BITS = 16;

    function automatic logic [8:0] mvb_slave_bits(input logic [2:0] len);
        case (len)
            3'd0:    return 9'd16;
            3'd1:    return 9'd32;
            3'd2:    return 9'd64;
            3'd3:    return 9'd128;
            3'd4:    return 9'd256;
            default: return 9'd16;
        endcase
    endfunction

    function automatic logic mvb_slave_len_bad(input logic [2:0] len);
        return len > 3'd4;
    endfunction

    // Serial CRC7, MSB of the data first, polynomial x^7+x^6+x^5+x^2+1.
    function automatic logic [6:0] mvb_crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? MVB_CRC_POLY : 7'd0);
    endfunction

    function automatic logic [7:0] mvb_check_byte(input logic [6:0] crc);
        return ~{crc, ^crc};
    endfunction

endpackage

// File: rtl/mvb_frame_receiver_if.sv
// Line-side inputs and word/status outputs of the MVB frame receiver.
// master drives the line and delimiter flags, slave is the receiver.
interface mvb_frame_receiver_if;
    import mvb_pkg::*;

    logic        data_in;
    logic        M_frame;
    logic        S_frame;
    logic        E_frame;
    logic [2:0]  slave_len;
    logic        frame_end_check;
    logic [15:0] word_data;
    logic        word_valid;
    logic        frame_type;
    logic        frame_done;
    logic        crc_err;
    logic        code_err;
    logic        len_err;

    modport master (
        output data_in, M_frame, S_frame, E_frame, slave_len,
        input  frame_end_check, word_data, word_valid, frame_type,
        input  frame_done, crc_err, code_err, len_err
    );

    modport slave (
        input  data_in, M_frame, S_frame, E_frame, slave_len,
        output frame_end_check, word_data, word_valid, frame_type,
        output frame_done, crc_err, code_err, len_err
    );
endinterface

// File: rtl/mvb_manchester_dec.sv
// Manchester bit decoder: 4 clocks per bit, halves sampled at phase 1 and 3, strobe on phase 3.
// No backpressure: the line cannot be stalled, o_bit/o_viol are only meaningful with o_stb.
module mvb_manchester_dec (
    input  logic clk_6M,
    input  logic rst,
    input  logic i_run,
    input  logic i_line,
    output logic o_bit,
    output logic o_stb,
    output logic o_viol
);
    logic [1:0] r_phase;
    logic       r_half1;

    always_ff @(negedge clk_6M or negedge rst) begin
        if (!rst) begin
            r_phase <= 2'd0;
            r_half1 <= 1'b0;
        end else if (!i_run) begin
            r_phase <= 2'd0;
        end else begin
            r_phase <= r_phase + 2'd1;
            if (r_phase == 2'd1)
                r_half1 <= i_line;
        end
    end

    // 1/0 is a one, 0/1 a zero; equal halves decode as zero and flag a violation.
    assign o_stb  = i_run && (r_phase == 2'd3);
    assign o_bit  = r_half1 & ~i_line;
    assign o_viol = r_half1 ~^ i_line;
endmodule

// File: rtl/mvb_frame_receiver.sv
// MVB frame receiver: decodes data/check groups, words appear 1 cycle after the 16th bit's last sample.
// No backpressure: word_valid is a pulse that must be taken; frame_done ends every completed frame.
module mvb_frame_receiver #(
    parameter int END_TIMEOUT = 8
) (
    input  logic                  clk_6M,
    input  logic                  rst,
    mvb_frame_receiver_if.slave   bus
);
    import mvb_pkg::*;

    localparam int            TW      = $clog2(END_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(END_TIMEOUT - 1);

    mvb_state_t    r_state, w_next;
    logic          r_m_d, r_s_d;
    logic [8:0]    r_bit_cnt, r_target;
    logic [6:0]    r_grp_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [14:0]   r_shift;
    logic [15:0]   r_word_data;
    logic [6:0]    r_crc, r_chk;
    logic          r_word_valid, r_frame_type, r_crc_err, r_code_err, r_len_err;
    logic          w_m_rise, w_s_rise, w_start, w_run;
    logic          w_bit, w_stb, w_viol;
    logic          w_data_last, w_grp_last, w_chk_last, w_timeout;

    mvb_manchester_dec u_dec (
        .clk_6M (clk_6M),
        .rst    (rst),
        .i_run  (w_run),
        .i_line (bus.data_in),
        .o_bit  (w_bit),
        .o_stb  (w_stb),
        .o_viol (w_viol)
    );

    assign w_m_rise    = bus.M_frame & ~r_m_d;
    assign w_s_rise    = bus.S_frame & ~r_s_d;
    assign w_start     = (r_state == ST_IDLE) && (w_m_rise || w_s_rise);
    assign w_run       = (r_state == ST_DATA) || (r_state == ST_CHECK);
    assign w_data_last = (9'(r_bit_cnt + 9'd1) == r_target);
    assign w_grp_last  = (r_grp_cnt == 7'(MVB_GROUP_BITS - 1));
    assign w_chk_last  = (r_grp_cnt == 7'd7);
    assign w_timeout   = (r_to_cnt == TO_LAST);

    always_ff @(negedge clk_6M or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_m_rise || w_s_rise) w_next = ST_DATA;
            ST_DATA:  if (w_stb && (w_grp_last || w_data_last)) w_next = ST_CHECK;
            ST_CHECK: if (w_stb && w_chk_last)
                          w_next = (r_bit_cnt == r_target) ? ST_END : ST_DATA;
            ST_END:   if (bus.E_frame || w_timeout) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.frame_end_check = 1'b0;
        bus.frame_done      = 1'b0;
        case (r_state)
            ST_END:  bus.frame_end_check = 1'b1;
            ST_DONE: bus.frame_done      = 1'b1;
            default: ;
        endcase
    end

    always_ff @(negedge clk_6M or negedge rst) begin
        if (!rst) begin
            r_m_d        <= 1'b0;
            r_s_d        <= 1'b0;
            r_bit_cnt    <= '0;
            r_target     <= '0;
            r_grp_cnt    <= '0;
            r_to_cnt     <= '0;
            r_shift      <= '0;
            r_word_data  <= '0;
            r_crc        <= '0;
            r_chk        <= '0;
            r_word_valid <= 1'b0;
            r_frame_type <= 1'b0;
            r_crc_err    <= 1'b0;
            r_code_err   <= 1'b0;
            r_len_err    <= 1'b0;
        end else begin
            r_m_d        <= bus.M_frame;
            r_s_d        <= bus.S_frame;
            r_word_valid <= 1'b0;

            // Master wins if both delimiters rise together.
            if (w_start) begin
                r_frame_type <= ~w_m_rise;
                r_target     <= w_m_rise ? 9'(MVB_MASTER_BITS) : mvb_slave_bits(bus.slave_len);
                r_len_err    <= ~w_m_rise & mvb_slave_len_bad(bus.slave_len);
                r_crc_err    <= 1'b0;
                r_code_err   <= 1'b0;
                r_bit_cnt    <= '0;
                r_grp_cnt    <= '0;
                r_crc        <= '0;
            end

            if (w_stb) begin
                if (w_viol) r_code_err <= 1'b1;
                if (r_state == ST_DATA) begin
                    r_shift   <= {r_shift[13:0], w_bit};
                    r_crc     <= mvb_crc7_step(r_crc, w_bit);
                    r_bit_cnt <= r_bit_cnt + 9'd1;
                    r_grp_cnt <= (w_grp_last || w_data_last) ? 7'd0 : r_grp_cnt + 7'd1;
                    if (r_bit_cnt[3:0] == 4'hF) begin
                        r_word_data  <= {r_shift, w_bit};
                        r_word_valid <= 1'b1;
                    end
                end else begin
                    r_chk     <= {r_chk[5:0], w_bit};
                    r_grp_cnt <= w_chk_last ? 7'd0 : r_grp_cnt + 7'd1;
                    if (w_chk_last) begin
                        if ({r_chk, w_bit} != mvb_check_byte(r_crc)) r_crc_err <= 1'b1;
                        r_crc <= '0;
                    end
                end
            end

            // A late E_frame on the final window cycle still counts as on time.
            if (r_state == ST_END) begin
                r_to_cnt <= r_to_cnt + TW'(1);
                if (w_timeout && !bus.E_frame) r_len_err <= 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign bus.word_data  = r_word_data;
    assign bus.word_valid = r_word_valid;
    assign bus.frame_type = r_frame_type;
    assign bus.crc_err    = r_crc_err;
    assign bus.code_err   = r_code_err;
    assign bus.len_err    = r_len_err;
endmodule

// File: tb/tb_mvb_frame_receiver.sv
// Bench for mvb_frame_receiver: directed vector table, reset abort sequence, random frames vs model.
module tb_mvb_frame_receiver;
    localparam int T = 8;

    logic clk_6M = 1'b0;
    logic rst    = 1'b0;

    mvb_frame_receiver_if bus ();

    mvb_frame_receiver #(.END_TIMEOUT(T)) dut (
        .clk_6M (clk_6M),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk_6M = ~clk_6M;

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          tx_data [0:255];
    bit          rx_data [0:255];
    logic [15:0] got_words [$];
    int          done_cnt;
    int          fec_cnt;
    logic        d_crc, d_code, d_len, d_type;

    typedef struct {
        bit          slave;
        logic [2:0]  slen;
        int          pat;
        int          e_dly;
        int          viol;
        int          flip;
        bit          x_crc;
        bit          x_code;
        bit          x_len;
        logic [15:0] x_w0;
        int          x_nw;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [22:0] outs();
        return {bus.frame_end_check, bus.word_data, bus.word_valid, bus.frame_type,
                bus.frame_done, bus.crc_err, bus.code_err, bus.len_err};
    endfunction

    // Sample on posedge, away from the receiver's negedge.
    task automatic tick();
        @(posedge clk_6M);
        if (bus.word_valid) got_words.push_back(bus.word_data);
        if (bus.frame_end_check) fec_cnt++;
        if (bus.frame_done) begin
            done_cnt++;
            d_crc  = bus.crc_err;
            d_code = bus.code_err;
            d_len  = bus.len_err;
            d_type = bus.frame_type;
        end
    endtask

    // Check byte by polynomial long division of the group followed by seven zeros.
    function automatic logic [7:0] model_check(input bit use_rx, input int s, input int n);
        bit         r [0:70];
        logic [7:0] gen;
        logic [6:0] rem;
        int         ones;
        gen = 8'hE5;
        for (int i = 0; i < 71; i++) r[i] = 1'b0;
        for (int i = 0; i < n; i++) r[i] = use_rx ? rx_data[s+i] : tx_data[s+i];
        for (int i = 0; i < n; i++)
            if (r[i])
                for (int k = 0; k < 8; k++) r[i+k] = r[i+k] ^ gen[7-k];
        ones = 0;
        for (int k = 0; k < 7; k++) begin
            rem[6-k] = r[n+k];
            ones += int'(r[n+k]);
        end
        return ~{rem, ones[0]};
    endfunction

    task automatic fill_pattern(input int pat);
        logic [15:0] w;
        for (int i = 0; i < 256; i++) begin
            case (pat)
                0:       w = 16'hA5C3;
                1:       w = 16'(i / 16 + 1);
                2:       w = 16'hFFFF;
                default: w = 16'($urandom_range(0, 65535));
            endcase
            tx_data[i] = w[15 - (i % 16)];
        end
    endtask

    task automatic run_frame(input bit slave, input logic [2:0] slen, input int e_dly,
                             input int viol, input int flip, input int abort_at, input string tag);
        int          target;
        bit          bad;
        bit          b;
        bit          line [$];
        logic [7:0]  ck;
        bit          x_crc, x_len, x_code, early;
        int          x_fec, nw;
        logic [15:0] w;

        bad    = slave && (slen > 3'd4);
        target = (slave && !bad) ? (16 << slen) : 16;
        for (int i = 0; i < target; i++)
            rx_data[i] = (i == viol) ? 1'b0 : (tx_data[i] ^ (i == flip));
        x_crc = 1'b0;
        for (int s = 0; s < target; s += 64) begin
            int n = (target - s < 64) ? target - s : 64;
            for (int i = s; i < s + n; i++) begin
                b = rx_data[i];
                if (i == viol) begin
                    repeat (4) line.push_back(1'b1);
                end else begin
                    line.push_back(b); line.push_back(b);
                    line.push_back(~b); line.push_back(~b);
                end
            end
            ck = model_check(1'b0, s, n);
            if (model_check(1'b1, s, n) != ck) x_crc = 1'b1;
            for (int k = 7; k >= 0; k--) begin
                line.push_back(ck[k]); line.push_back(ck[k]);
                line.push_back(~ck[k]); line.push_back(~ck[k]);
            end
        end
        x_code = (viol >= 0) && (viol < target);
        x_len  = bad || (e_dly < 0) || (e_dly >= T);
        x_fec  = (e_dly >= 0 && e_dly < T) ? e_dly + 1 : T;

        got_words.delete();
        done_cnt = 0; fec_cnt = 0; early = 1'b0;
        d_crc = 1'bx; d_code = 1'bx; d_len = 1'bx; d_type = 1'bx;
        bus.slave_len = slen;
        tick();
        if (slave) bus.S_frame = 1'b1; else bus.M_frame = 1'b1;
        for (int j = 0; j < line.size(); j++) begin
            tick();
            if (bus.frame_end_check) early = 1'b1;
            if (j == abort_at) begin
                #2 rst = 1'b0;
                #1 check({tag, "_rst_outs"}, 32'(outs()), 32'd0);
                repeat (3) tick();
                bus.M_frame = 1'b0; bus.S_frame = 1'b0; bus.data_in = 1'b0;
                rst = 1'b1;
                repeat (20) tick();
                check({tag, "_no_done"}, done_cnt, 0);
                check({tag, "_idle_outs"}, 32'(outs()), 32'd0);
                return;
            end
            bus.data_in = line[j];
        end
        tick();
        check({tag, "_fec_rise"}, bus.frame_end_check, 1);
        check({tag, "_fec_early"}, early, 0);
        for (int c = 0; c < T + 4 && done_cnt == 0; c++) begin
            bus.E_frame = (c == e_dly);
            tick();
        end
        bus.E_frame = 1'b0; bus.M_frame = 1'b0; bus.S_frame = 1'b0; bus.data_in = 1'b0;
        tick(); tick();
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_fec_cycles"}, fec_cnt, x_fec);
        check({tag, "_crc_err"}, d_crc, x_crc);
        check({tag, "_code_err"}, d_code, x_code);
        check({tag, "_len_err"}, d_len, x_len);
        check({tag, "_type"}, d_type, slave);
        nw = target / 16;
        check({tag, "_nwords"}, got_words.size(), nw);
        for (int i = 0; i < nw && i < got_words.size(); i++) begin
            for (int k = 0; k < 16; k++) w[15-k] = rx_data[16*i + k];
            check($sformatf("%s_word%0d", tag, i), got_words[i], w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.data_in = 1'b0; bus.M_frame = 1'b0; bus.S_frame = 1'b0;
        bus.E_frame = 1'b0; bus.slave_len = 3'd0;
        repeat (3) @(posedge clk_6M);
        #1 check("reset_outs", 32'(outs()), 32'd0);
        @(posedge clk_6M);
        rst = 1'b1;
        repeat (2) tick();
        check("idle_outs", 32'(outs()), 32'd0);

        //           slave slen pat e_dly viol flip crc code len w0        nw
        vecs[0] = '{1'b0, 3'd0, 0, 0,   -1,  -1,  0,  0,   0, 16'hA5C3,  1};
        vecs[1] = '{1'b1, 3'd3, 1, 2,   -1,  -1,  0,  0,   0, 16'h0001,  8};
        vecs[2] = '{1'b1, 3'd3, 1, 1,   -1,  69,  1,  0,   0, 16'h0001,  8};
        vecs[3] = '{1'b0, 3'd0, 2, 0,    3,  -1,  1,  1,   0, 16'hEFFF,  1};
        vecs[4] = '{1'b0, 3'd0, 0, -1,  -1,  -1,  0,  0,   1, 16'hA5C3,  1};
        vecs[5] = '{1'b1, 3'd5, 0, 0,   -1,  -1,  0,  0,   1, 16'hA5C3,  1};
        vecs[6] = '{1'b0, 3'd0, 0, T-1, -1,  -1,  0,  0,   0, 16'hA5C3,  1};
        vecs[7] = '{1'b0, 3'd0, 0, T,   -1,  -1,  0,  0,   1, 16'hA5C3,  1};
        vecs[8] = '{1'b1, 3'd0, 1, 1,   -1,  -1,  0,  0,   0, 16'h0001,  1};
        vecs[9] = '{1'b1, 3'd4, 1, 3,   -1,  -1,  0,  0,   0, 16'h0001, 16};

        for (int v = 0; v < 10; v++) begin
            fill_pattern(vecs[v].pat);
            run_frame(vecs[v].slave, vecs[v].slen, vecs[v].e_dly, vecs[v].viol,
                      vecs[v].flip, -1, $sformatf("v%0d", v));
            check($sformatf("v%0d_tbl_crc", v), d_crc, vecs[v].x_crc);
            check($sformatf("v%0d_tbl_code", v), d_code, vecs[v].x_code);
            check($sformatf("v%0d_tbl_len", v), d_len, vecs[v].x_len);
            check($sformatf("v%0d_tbl_nw", v), got_words.size(), vecs[v].x_nw);
            if (got_words.size() > 0)
                check($sformatf("v%0d_tbl_w0", v), got_words[0], vecs[v].x_w0);
            else
                check($sformatf("v%0d_tbl_w0", v), 32'hxxxx_dead, vecs[v].x_w0);
        end

        // Reset in the middle of slave data, then a clean master frame.
        fill_pattern(1);
        run_frame(1'b1, 3'd3, 0, -1, -1, 150, "abort");
        fill_pattern(0);
        run_frame(1'b0, 3'd0, 1, -1, -1, -1, "after_rst");
        check("after_rst_w0", got_words.size() > 0 ? 32'(got_words[0]) : 32'hdead, 32'hA5C3);

        for (int r = 0; r < 6; r++) begin
            bit         sl;
            logic [2:0] len;
            int         ed, vi, fl;
            sl  = 1'($urandom_range(0, 1));
            len = 3'($urandom_range(0, 5));
            ed  = int'($urandom_range(0, T + 1)) - 1;
            vi  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
            fl  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
            fill_pattern(3);
            run_frame(sl, len, ed, vi, fl, -1, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mvb_frame_receiver.md
# mvb_frame_receiver

Downstream stage of `delimiter_check` on the MVB receive path. Once a master or slave start delimiter has been recognised, the block Manchester-decodes the line and assembles the data bits into 16-bit words. It checks each 8-bit check sequence and raises `frame_end_check` so the delimiter stage can look for the end delimiter. It ends every frame with a single status pulse.

## Interface
Parameters:
- `END_TIMEOUT`, default 8: clk_6M cycles allowed for `E_frame` after `frame_end_check` rises.

Ports:
- `clk_6M`  in  1  sample clock; 4 cycles per MVB bit (1.5 Mbit/s); all logic on negedge
- `rst`  in  1  reset, asynchronous, active-low
- `data_in`  in  1  raw Manchester line
- `M_frame`  in  1  master start delimiter seen (level, from delimiter_check)
- `S_frame`  in  1  slave start delimiter seen
- `E_frame`  in  1  end delimiter seen
- `slave_len`  in  3  expected slave data size: 0=16, 1=32, 2=64, 3=128, 4=256 bits; 5–7 are illegal
- `frame_end_check`  out  1  end-delimiter window; this is the input of the same name on delimiter_check
- `word_data`  out  16  received word, MSB first on the line
- `word_valid`  out  1  one-cycle pulse per word
- `frame_type`  out  1  0=master, 1=slave; held from frame start
- `frame_done`  out  1  one-cycle pulse at frame end
- `crc_err`  out  1  sticky for the frame; valid with `frame_done`
- `code_err`  out  1  Manchester violation; sticky; valid with `frame_done`
- `len_err`  out  1  end delimiter missing or late; valid with `frame_done`

## Operation
- **States:** IDLE, DATA, CHECK, END, DONE.
- **IDLE → DATA** on the rising edge of `M_frame` or `S_frame`.
  - `frame_type` is latched.
  - Bit count target: master 16; slave per `slave_len`. Illegal `slave_len` is treated as 16 and sets `len_err`.
- **Bit decode:** the phase counter runs 0..3.
  - First half-bit is sampled at phase 1, second half at phase 3.
  - 1/0 decodes as bit 1; 0/1 decodes as bit 0.
  - Equal halves set `code_err`; the bit is still shifted in as 0.
- **DATA:**
  - Bits shift into a 16-bit register.
  - On every 16th bit, `word_data` and `word_valid` are produced.
  - After each group of 64 data bits, or at the end of data if sooner, the FSM goes to CHECK.
- **CHECK:**
  - 8 check bits are received.
  - CRC7 uses polynomial x^7+x^6+x^5+x^2+1, initial value 0, computed over the group's data bits.
  - Expected check byte = ~{crc[6:0], p}, where p makes {crc,p} even parity.
  - A mismatch sets `crc_err`.
  - The CRC is cleared after each group.
  - The FSM then returns to DATA if data bits remain, otherwise goes to END.
- **END:**
  - `frame_end_check` = 1.
  - `E_frame` seen within `END_TIMEOUT` cycles → DONE.
  - Timeout → `len_err`, then DONE.
- **DONE:** `frame_done` pulses, `frame_end_check` drops, and the FSM returns to IDLE. Error flags clear on the next frame start.
- A new `M_frame`/`S_frame` rise outside IDLE is ignored.

## Timing
- **Reset values:** all outputs 0, FSM in IDLE, counters 0. Reset mid-frame aborts with no `frame_done`.
- **Bit alignment:** the first data bit begins the clk_6M cycle after the `M_frame`/`S_frame` rise; phase counter = 0 there.
- **`word_valid`:** one cycle after the phase-3 sample of the 16th bit. `word_data` is stable until the next `word_valid`.
- **`frame_end_check`:** asserted the cycle after the last check bit's phase-3 sample.
- **`frame_done`:** asserted the cycle after `E_frame` is seen, or after the timeout expires. If `E_frame` and the timeout coincide, `E_frame` wins.
- **Frame lengths** from delimiter rise to `frame_end_check`: master (16+8)×4 = 96 cycles; slave 256 = (256+4×8)×4 = 1152 cycles.
- **Counter widths:**
  - Data bit count: 9 bits (max 256).
  - Group count: 7 bits.
  - Timeout counter: $clog2(END_TIMEOUT+1) bits.

## Structure
- **Shared package `mvb_pkg`:**
  - FSM state enum
  - CRC polynomial constant 7'h65
  - `slave_len` decode function
  - Bits-per-group constant 64
  - `mvb_check_byte()` function
- **Sub-module `mvb_manchester_dec`:** phase counter, half-bit samples, bit/strobe/violation outputs. It is reused by the future transmit loopback checker.

## Test plan
- Master frame, data 16'hA5C3 with correct check byte → one `word_valid` with `word_data`=A5C3; `frame_done` with all error flags 0; `frame_type`=0.
- Slave frame, `slave_len`=3 (128 bits), 8 words 0x0001..0x0008 with two correct check bytes → 8 `word_valid` pulses in order; `frame_type`=1; `crc_err`=0.
- Same slave frame with bit 5 of the second group flipped → `crc_err`=1 at `frame_done`; all 8 words still delivered.
- Master frame whose bit 3 is sent as 1/1 → `code_err`=1; `word_data` bit 12 = 0.
- Valid master frame with `E_frame` never asserted → `frame_end_check` high for `END_TIMEOUT` cycles, then `frame_done` with `len_err`=1.
- `rst` pulled low mid-DATA of a slave frame → all outputs 0 immediately; no `frame_done`; the next master frame decodes correctly.
